// File: rtl/phase_seq_pkg.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// phase_seq_pkg: shared constants, adjust-state encoding and phase decode
// rev 1.0
////////////////////////////////////////////////////////////////////////////////
package phase_seq_pkg;

  localparam logic ADJ_ADVANCE = 1'b0;
  localparam logic ADJ_RETARD  = 1'b1;

  localparam int unsigned c_NOV_DEFAULT   = 4;
  localparam int unsigned c_SYM_W_DEFAULT = 8;

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_STALL = 1'b1
  } adj_state_e;

  typedef struct packed {
    logic max;
    logic half_or_max;
    logic first;
  } phase_dec_t;

  // With NOV = 2 the half point collapses onto the max phase.
  function automatic phase_dec_t phase_decode(input int unsigned phase,
                                              input int unsigned nov,
                                              input logic        after_adv);
    phase_dec_t  d;
    int unsigned half_ph;
    half_ph       = (nov == 32'd2) ? 32'd1 : (nov / 32'd2) - 32'd1;
    d.max         = (phase == nov - 32'd1);
    d.half_or_max = d.max || (phase == half_ph);
    d.first       = (phase == 32'd0) || (after_adv && (phase == 32'd1));
    return d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/phase_seq_adj.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// phase_seq_adj: qualifies timing-adjust requests at the wrap, rearm and stall
// rev 1.0
////////////////////////////////////////////////////////////////////////////////
module phase_seq_adj
  import phase_seq_pkg::*;
(
  input  logic clk,
  input  logic i_reset,
  input  logic i_enable,
  input  logic i_at_wrap,
  input  logic i_adj_req,
  input  logic i_adj_dir,
  output logic o_take_adv,
  output logic o_take_ret,
  output logic o_stall
);

  adj_state_e r_state;
  logic       r_armed;
  logic       w_take;

  // A request is only honoured once per assertion; rearm needs a low cycle.
  assign w_take     = i_enable & i_at_wrap & (r_state == ST_RUN) & i_adj_req & r_armed;
  assign o_take_adv = w_take & (i_adj_dir == ADJ_ADVANCE);
  assign o_take_ret = w_take & (i_adj_dir == ADJ_RETARD);
  assign o_stall    = (r_state == ST_STALL);

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_state <= ST_RUN;
      r_armed <= 1'b1;
    end else begin
      case (r_state)
        ST_RUN:   if (o_take_ret) r_state <= ST_STALL;
        ST_STALL: if (i_enable)   r_state <= ST_RUN;
        default:                  r_state <= ST_RUN;
      endcase
      if (w_take) begin
        r_armed <= 1'b0;
      end else if (!i_adj_req) begin
        r_armed <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/phase_sequencer.sv
`default_nettype none
////////////////////////////////////////////////////////////////////////////////
// phase_sequencer: modulo-NOV phase, symbol strobes, symbol counter and
// optional timing adjust (`define PHASE_SEQ_ADJ_EN)               rev 1.0
////////////////////////////////////////////////////////////////////////////////
module phase_sequencer
  import phase_seq_pkg::*;
#(
  parameter int unsigned NOV       = c_NOV_DEFAULT,
  parameter int unsigned PH_W      = $clog2(NOV),
  parameter int unsigned RST_PHASE = NOV - 2,
  parameter int unsigned SYM_W     = c_SYM_W_DEFAULT
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_adj_req,
  input  logic             i_adj_dir,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_count_max,
  output logic             o_count_half_or_max,
  output logic             o_save_shifters,
  output logic             o_stall,
  output logic [SYM_W-1:0] o_sym_cnt,
  output logic             o_adj_ack
);

  localparam logic [PH_W-1:0] c_PH_MAX = PH_W'(NOV - 1);
  localparam logic [PH_W-1:0] c_PH_RST = PH_W'(RST_PHASE);

  logic [PH_W-1:0]  r_phase;
  logic             r_count_max;
  logic             r_half_or_max;
  logic             r_save;
  logic             r_adj_ack;
  logic [SYM_W-1:0] r_sym_cnt;

  logic             w_take_adv;
  logic             w_take_ret;
  logic             w_stall;
  logic [PH_W-1:0]  w_phase_nxt;
  logic             w_after_adv;
  phase_dec_t       w_dec;

`ifdef PHASE_SEQ_ADJ_EN
  logic w_at_wrap;
  assign w_at_wrap = (r_phase == c_PH_MAX);

  phase_seq_adj u_adj (
    .clk        (clk),
    .i_reset    (i_reset),
    .i_enable   (i_enable),
    .i_at_wrap  (w_at_wrap),
    .i_adj_req  (i_adj_req),
    .i_adj_dir  (i_adj_dir),
    .o_take_adv (w_take_adv),
    .o_take_ret (w_take_ret),
    .o_stall    (w_stall)
  );
`else
  logic w_unused_adj;
  assign w_take_adv   = 1'b0;
  assign w_take_ret   = 1'b0;
  assign w_stall      = 1'b0;
  assign w_unused_adj = i_adj_req ^ i_adj_dir;
`endif

  // Strobes are decoded from the next phase so they line up with o_phase.
  always_comb begin
    w_phase_nxt = r_phase;
    w_after_adv = 1'b0;
    if (w_stall) begin
      w_phase_nxt = '0;
    end else if (w_take_adv) begin
      w_phase_nxt = PH_W'(1);
      w_after_adv = 1'b1;
    end else if (w_take_ret) begin
      w_phase_nxt = r_phase;
    end else if (r_phase == c_PH_MAX) begin
      w_phase_nxt = '0;
    end else begin
      w_phase_nxt = r_phase + PH_W'(1);
    end
    w_dec = phase_decode(32'(w_phase_nxt), NOV, w_after_adv);
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      r_phase       <= c_PH_RST;
      r_count_max   <= 1'b0;
      r_half_or_max <= 1'b0;
      r_save        <= 1'b0;
      r_adj_ack     <= 1'b0;
      r_sym_cnt     <= '0;
    end else if (!i_enable) begin
      r_count_max   <= 1'b0;
      r_half_or_max <= 1'b0;
      r_save        <= 1'b0;
      r_adj_ack     <= 1'b0;
    end else begin
      r_phase       <= w_phase_nxt;
      r_count_max   <= w_dec.max & ~w_take_ret;
      r_half_or_max <= w_dec.half_or_max & ~w_take_ret;
      r_save        <= w_dec.first & ~w_take_ret;
      r_adj_ack     <= w_take_adv | w_take_ret;
      if (w_dec.max && !w_take_ret) begin
        r_sym_cnt <= r_sym_cnt + SYM_W'(1);
      end
    end
  end

  assign o_phase             = r_phase;
  assign o_count_max         = r_count_max;
  assign o_count_half_or_max = r_half_or_max;
  assign o_save_shifters     = r_save;
  assign o_stall             = w_stall;
  assign o_sym_cnt           = r_sym_cnt;
  assign o_adj_ack           = r_adj_ack;

endmodule
`default_nettype wire
